regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-entry pending scoreboard and a post-reset clear sweep.
// Reads are combinational, with a write-first bypass from the write-back port.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_wa,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rv1,
    output logic             rv2,
    output logic             busy
);
    localparam int            DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [WIDTH-1:0] rf_q [DEPTH];

    logic wr_ok;
    logic iss_ok;

    assign wr_ok  = we     && !(ZERO_REG && (wa     == '0));
    assign iss_ok = iss_en && !(ZERO_REG && (iss_wa == '0));

    // NOTE: blocking assignments in always_comb; the later issue assignment
    // deliberately overrides the write-back clear for the same entry.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)  pend_d[wa]     = 1'b0;
        if (iss_ok) pend_d[iss_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST) state_q <= READY;
                end
                READY:   pend_q  <= pend_d;
                default: state_q <= CLEAR;
            endcase
        end
    end

    // NOTE: the array has no reset term; the CLEAR sweep zeroes one entry per
    // cycle so the storage maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)  rf_q[ptr_q] <= '0;
            else if (wr_ok)        rf_q[wa]    <= wd;
        end
    end

    // Returns {valid, data} for one read port.
    function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH:0] r;
        if (state_q != READY)                r = '0;
        else if (ZERO_REG && (ra == '0))     r = {1'b1, {WIDTH{1'b0}}};
        else if (we && (wa == ra))           r = {1'b1, wd};
        else                                 r = {~pend_q[ra], rf_q[ra]};
        return r;
    endfunction

    always_comb begin
        {rv1, rd1} = read_port(ra1);
        {rv2, rd2} = read_port(ra2);
    end

    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand-written
// reset sequences, and randomized traffic against a behavioural model.
module tb_regfile_sb;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we = 1'b0;
    logic [AW-1:0]    wa = '0;
    logic [WIDTH-1:0] wd = '0;
    logic             iss_en = 1'b0;
    logic [AW-1:0]    iss_wa = '0;
    logic [AW-1:0]    ra1 = '0;
    logic [AW-1:0]    ra2 = '0;
    logic [WIDTH-1:0] rd1, rd2;
    logic             rv1, rv2, busy;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .iss_en(iss_en), .iss_wa(iss_wa), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: sweep countdown, data array, pending flags.
    logic [WIDTH-1:0] m_mem  [DEPTH];
    bit               m_pend [DEPTH];
    int               m_sweep = DEPTH;

    task automatic model_clock();
        if (rst) begin
            m_sweep = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else begin
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (iss_en && iss_wa != 0) m_pend[iss_wa] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] ra, output logic [WIDTH-1:0] d, output logic v);
        if (m_sweep > 0)          begin d = '0;        v = 1'b0; end
        else if (ra == 0)         begin d = '0;        v = 1'b1; end
        else if (we && wa == ra)  begin d = wd;        v = 1'b1; end
        else                      begin d = m_mem[ra]; v = !m_pend[ra]; end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_in(input logic r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input logic ie, input logic [AW-1:0] ia, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rst = r; we = w; wa = a; wd = d; iss_en = ie; iss_wa = ia; ra1 = a1; ra2 = a2;
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] e1, e2;
        logic             v1, v2;
        model_read(ra1, e1, v1);
        model_read(ra2, e2, v2);
        check({tag, ".busy"}, {31'b0, busy}, {31'b0, m_sweep > 0});
        check({tag, ".rd1"}, rd1, e1);
        check({tag, ".rv1"}, {31'b0, rv1}, {31'b0, v1});
        check({tag, ".rd2"}, rd2, e2);
        check({tag, ".rv2"}, {31'b0, rv2}, {31'b0, v2});
    endtask

    typedef struct {
        logic             we;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic             iss_en;
        logic [AW-1:0]    iss_wa;
        logic [AW-1:0]    ra1;
        logic [AW-1:0]    ra2;
        logic [WIDTH-1:0] rd1;
        logic             rv1;
        logic [WIDTH-1:0] rd2;
        logic             rv2;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                                input logic ie, input logic [AW-1:0] ia, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [WIDTH-1:0] e1, input logic v1,
                                input logic [WIDTH-1:0] e2, input logic v2);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.iss_en = ie; v.iss_wa = ia; v.ra1 = a1; v.ra2 = a2;
        v.rd1 = e1; v.rv1 = v1; v.rd2 = e2; v.rv2 = v2;
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    vec_t tbl [16];

    initial begin
        // Directed vectors, applied from the READY state with every entry zero.
        tbl[0]  = mk(1, 7,  32'hDEADBEEF, 0, 0, 7,  0,  32'hDEADBEEF, 1, 32'h0,        1);
        tbl[1]  = mk(0, 0,  32'h0,        0, 0, 7,  7,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        tbl[2]  = mk(1, 0,  32'h12345678, 0, 0, 0,  0,  32'h0,        1, 32'h0,        1);
        tbl[3]  = mk(0, 0,  32'h0,        0, 0, 7,  0,  32'hDEADBEEF, 1, 32'h0,        1);
        tbl[4]  = mk(0, 0,  32'h0,        1, 0, 0,  0,  32'h0,        1, 32'h0,        1);
        tbl[5]  = mk(0, 0,  32'h0,        0, 0, 0,  0,  32'h0,        1, 32'h0,        1);
        tbl[6]  = mk(0, 0,  32'h0,        1, 9, 9,  9,  32'h0,        1, 32'h0,        1);
        tbl[7]  = mk(0, 0,  32'h0,        0, 0, 9,  7,  32'h0,        0, 32'hDEADBEEF, 1);
        tbl[8]  = mk(1, 9,  32'h55,       0, 0, 9,  9,  32'h55,       1, 32'h55,       1);
        tbl[9]  = mk(0, 0,  32'h0,        0, 0, 9,  9,  32'h55,       1, 32'h55,       1);
        tbl[10] = mk(1, 9,  32'h66,       1, 9, 9,  3,  32'h66,       1, 32'h0,        1);
        tbl[11] = mk(0, 0,  32'h0,        0, 0, 9,  9,  32'h66,       0, 32'h66,       0);
        tbl[12] = mk(1, 15, 32'hA5A5A5A5, 0, 0, 1,  2,  32'h0,        1, 32'h0,        1);
        tbl[13] = mk(0, 0,  32'h0,        0, 0, 15, 15, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1);
        tbl[14] = mk(1, 9,  32'h77,       0, 0, 9,  15, 32'h77,       1, 32'hA5A5A5A5, 1);
        tbl[15] = mk(0, 0,  32'h0,        0, 0, 9,  15, 32'h77,       1, 32'hA5A5A5A5, 1);

        // Reset sweep: rst high for three edges, then exactly DEPTH busy cycles.
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            check("rst.busy", {31'b0, busy}, 32'd1);
            check("rst.rv1", {31'b0, rv1}, 32'd0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            #3;
            check($sformatf("sweep.busy%0d", i), {31'b0, busy}, 32'd1);
            tick();
        end
        #3;
        check("sweep.done", {31'b0, busy}, 32'd0);
        for (int a = 0; a < DEPTH; a += 2) begin
            set_in(0, 0, 0, 0, 0, 0, AW'(a), AW'(a + 1));
            #3;
            check($sformatf("clr.rd%0d", a),     rd1, 32'h0);
            check($sformatf("clr.rv%0d", a),     {31'b0, rv1}, 32'd1);
            check($sformatf("clr.rd%0d", a + 1), rd2, 32'h0);
            check($sformatf("clr.rv%0d", a + 1), {31'b0, rv2}, 32'd1);
            tick();
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 16; i++) begin
            set_in(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iss_en, tbl[i].iss_wa, tbl[i].ra1, tbl[i].ra2);
            #3;
            check($sformatf("vec%0d.rd1", i), rd1, tbl[i].rd1);
            check($sformatf("vec%0d.rv1", i), {31'b0, rv1}, {31'b0, tbl[i].rv1});
            check($sformatf("vec%0d.rd2", i), rd2, tbl[i].rd2);
            check($sformatf("vec%0d.rv2", i), {31'b0, rv2}, {31'b0, tbl[i].rv2});
            check($sformatf("vec%0d.busy", i), {31'b0, busy}, 32'd0);
            tick();
        end

        // Reset mid-sweep restarts the full sweep; traffic while busy is ignored.
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        #3;
        check("mid.busy_before", {31'b0, busy}, 32'd1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 1, 5, 32'hBAD0 + i, 1, 6, 5, 15);
            #3;
            check($sformatf("mid.busy%0d", i), {31'b0, busy}, 32'd1);
            check($sformatf("mid.rd1_%0d", i), rd1, 32'h0);
            check($sformatf("mid.rv1_%0d", i), {31'b0, rv1}, 32'd0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 5, 6);
        #3;
        check("mid.done", {31'b0, busy}, 32'd0);
        check("mid.rd5", rd1, 32'h0);
        check("mid.rv5", {31'b0, rv1}, 32'd1);
        check("mid.rd6", rd2, 32'h0);
        check("mid.rv6", {31'b0, rv2}, 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 15, 7);
        #3;
        check("mid.rd15", rd1, 32'h0);
        check("mid.rd7", rd2, 32'h0);
        tick();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
                   $urandom_range(0, 2) == 0, rnd_addr(), rnd_addr(), rnd_addr());
            #3;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
